stream_wrr_scheduler: RTL and testbench

Packet-atomic weighted round-robin scheduler that merges STREAM_COUNT valid/ready streams onto one master stream. Each stream gets a per-epoch beat budget set by its weight, and the budgets reload when every requesting stream has used its budget. The block sits in the same stream fabric as the QoS arbiter. It is used where bandwidth must be shared by proportion rather than by strict priority, and it has no starvation of low-priority sources.

---
 rtl/stream_wrr_scheduler_if.sv | 27 ++
 rtl/stream_wrr_scheduler.sv | 135 +++++++++++++
 tb/tb_stream_wrr_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_wrr_scheduler_if.sv
// Stream bundle between the WRR scheduler and the fabric: STREAM_COUNT slave
// streams in, one merged master stream out.
interface stream_wrr_scheduler_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int STREAM_COUNT = 4,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
);
    logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_in;
    logic [STREAM_COUNT-1:0]                   s_last_in;
    logic [STREAM_COUNT-1:0]                   s_valid_in;
    logic [STREAM_COUNT-1:0]                   s_ready_out;
    logic [T_DATA_WIDTH-1:0]                   m_data_out;
    logic [T_ID___WIDTH-1:0]                   m_id_out;
    logic                                      m_last_out;
    logic                                      m_valid_out;
    logic                                      m_ready_in;

    // slave: the scheduler; master: the fabric feeding sources and sinking the merge
    modport slave (
        input  s_data_in, s_last_in, s_valid_in, m_ready_in,
        output s_ready_out, m_data_out, m_id_out, m_last_out, m_valid_out
    );
    modport master (
        output s_data_in, s_last_in, s_valid_in, m_ready_in,
        input  s_ready_out, m_data_out, m_id_out, m_last_out, m_valid_out
    );
endinterface

// File: rtl/stream_wrr_scheduler.sv
// Packet-atomic weighted round-robin merge of STREAM_COUNT streams; per-stream
// beat credits reload from the weights once no requester has credit left.
module stream_wrr_credit #(
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    reload_i,
    input  logic                    dec_i,
    input  logic [WEIGHT_WIDTH-1:0] weight_i,
    output logic                    nz_o
);
    logic [WEIGHT_WIDTH-1:0] credit_q;

    // Saturating: beats past the budget inside one packet are not carried over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
        end else if (reload_i) begin
            credit_q <= weight_i;
        end else if (dec_i && credit_q != '0) begin
            credit_q <= credit_q - WEIGHT_WIDTH'(1);
        end
    end

    assign nz_o = |credit_q;
endmodule

module stream_wrr_scheduler #(
    parameter int T_DATA_WIDTH = 8,
    parameter int STREAM_COUNT = 4,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    stream_wrr_scheduler_if.slave                      bus,
    input  logic [STREAM_COUNT-1:0][WEIGHT_WIDTH-1:0]  s_weight_in,
    output logic                                       epoch_out
);
    typedef enum logic [0:0] {IDLE, ACTIVE} state_e;

    state_e                  state_q;
    logic [T_ID___WIDTH-1:0] sel_q, sel_d;
    logic [T_ID___WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                    epoch_q;

    logic [STREAM_COUNT-1:0] credit_nz, elig, dec, s_ready, rot;
    logic [T_ID___WIDTH:0]   cand;
    logic [T_DATA_WIDTH-1:0] sel_data;
    logic                    active, any_elig, reload, sel_valid, beat, last_beat;

    for (genvar i = 0; i < STREAM_COUNT; i++) begin : g_lane
        stream_wrr_credit #(.WEIGHT_WIDTH(WEIGHT_WIDTH)) u_credit (
            .clk      (clk),
            .rst_n    (rst_n),
            .reload_i (reload),
            .dec_i    (dec[i]),
            .weight_i (s_weight_in[i]),
            .nz_o     (credit_nz[i])
        );
    end

    assign elig = bus.s_valid_in & credit_nz;

    // Rotate so bit k is stream (rr_ptr+k) mod N; lowest k wins.
    always_comb begin
        sel_d    = sel_q;
        any_elig = 1'b0;
        cand     = '0;
        rot      = STREAM_COUNT'({elig, elig} >> rr_ptr_q);
        for (int k = STREAM_COUNT - 1; k >= 0; k--) begin
            if (rot[k]) begin
                cand = {1'b0, rr_ptr_q} + (T_ID___WIDTH + 1)'(k);
                if (cand >= (T_ID___WIDTH + 1)'(STREAM_COUNT)) begin
                    cand = cand - (T_ID___WIDTH + 1)'(STREAM_COUNT);
                end
                sel_d    = cand[T_ID___WIDTH-1:0];
                any_elig = 1'b1;
            end
        end
    end

    assign active    = (state_q == ACTIVE);
    assign sel_valid = active & bus.s_valid_in[sel_q];
    assign beat      = sel_valid & bus.m_ready_in;
    assign last_beat = beat & bus.s_last_in[sel_q];
    assign reload    = ~active & ~any_elig & (|bus.s_valid_in);
    assign rr_ptr_d  = (sel_q == T_ID___WIDTH'(STREAM_COUNT - 1)) ? '0
                                                                 : sel_q + T_ID___WIDTH'(1);

    always_comb begin
        s_ready = '0;
        dec     = '0;
        if (active) s_ready[sel_q] = bus.m_ready_in;
        if (beat)   dec[sel_q]     = 1'b1;
    end

    assign sel_data        = bus.s_data_in[sel_q];
    assign bus.s_ready_out = s_ready;
    assign bus.m_valid_out = sel_valid;
    assign bus.m_last_out  = active & bus.s_last_in[sel_q];
    assign bus.m_data_out  = active ? sel_data : '0;
    assign bus.m_id_out    = active ? sel_q : '0;
    assign epoch_out       = epoch_q;

    // Grant is taken regardless of m_ready_in; a reload cycle never grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            epoch_q  <= 1'b0;
        end else begin
            epoch_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        sel_q   <= sel_d;
                        state_q <= ACTIVE;
                    end else if (reload) begin
                        epoch_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (last_beat) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_wrr_scheduler.sv
// Directed bench: a 4-stream and a 3-stream scheduler fed from beat queues,
// accepted master beats logged and compared with hand-derived sequences.
module tb_stream_wrr_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_wrr_scheduler_if #(.T_DATA_WIDTH(8), .STREAM_COUNT(4)) bus ();
    stream_wrr_scheduler_if #(.T_DATA_WIDTH(8), .STREAM_COUNT(3)) bus3 ();
    logic [3:0][3:0] weight;
    logic [2:0][3:0] weight3;
    logic            epoch, epoch3;

    stream_wrr_scheduler #(.T_DATA_WIDTH(8), .STREAM_COUNT(4), .WEIGHT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .s_weight_in(weight), .epoch_out(epoch)
    );
    stream_wrr_scheduler #(.T_DATA_WIDTH(8), .STREAM_COUNT(3), .WEIGHT_WIDTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .s_weight_in(weight3), .epoch_out(epoch3)
    );

    // per-stream beat queues {last, data} for the 4-stream DUT
    logic [8:0] src_mem [4][16];
    int         src_hd [4] = '{default: 0};
    int         src_tl [4] = '{default: 0};
    logic [3:0] hold = '0;
    logic       flush = 1'b0;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.s_valid_in[i] = (src_hd[i] < src_tl[i]) && !hold[i];
            bus.s_data_in[i]  = src_mem[i][src_hd[i][3:0]][7:0];
            bus.s_last_in[i]  = src_mem[i][src_hd[i][3:0]][8];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (flush) src_hd[i] <= src_tl[i];
            else if (bus.s_valid_in[i] && bus.s_ready_out[i]) src_hd[i] <= src_hd[i] + 1;
        end
    end

    int         mon_n = 0, ep_n = 0, mon3_n = 0, ep3_n = 0;
    logic [7:0] mon_id [64];
    logic [7:0] mon_dat [64];
    logic       mon_last [64];
    logic [7:0] mon3_id [64];

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.m_valid_out && bus.m_ready_in) begin
                mon_id[mon_n[5:0]]   <= 8'(bus.m_id_out);
                mon_dat[mon_n[5:0]]  <= bus.m_data_out;
                mon_last[mon_n[5:0]] <= bus.m_last_out;
                mon_n <= mon_n + 1;
            end
            if (epoch) ep_n <= ep_n + 1;
            if (bus3.m_valid_out && bus3.m_ready_in) begin
                mon3_id[mon3_n[5:0]] <= 8'(bus3.m_id_out);
                mon3_n <= mon3_n + 1;
            end
            if (epoch3) ep3_n <= ep3_n + 1;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        src_mem[s][src_tl[s][3:0]] = {l, d};
        src_tl[s] = src_tl[s] + 1;
    endtask

    task automatic wait_mon(input int n, input string tag);
        int t = 0;
        while (mon_n < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(mon_n >= n), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b1;
        hold  = '0;
        bus.m_ready_in = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int base, eb, t;
    int eid_b [8] = '{0, 1, 0, 0, 1, 0, 0, 0};
    int edt_b [8] = '{8'h00, 8'h10, 8'h01, 8'h02, 8'h11, 8'h03, 8'h04, 8'h05};
    int eid_e [5] = '{0, 1, 2, 0, 1};

    initial begin
        // reset state: outputs stay 0 while an input is valid and ready is high
        rst_n = 1'b0;
        flush = 1'b1;
        weight  = {4{4'd2}};
        weight3 = {3{4'd1}};
        bus.m_ready_in   = 1'b1;
        bus3.s_valid_in  = '0;
        bus3.s_last_in   = 3'b111;
        bus3.s_data_in   = {8'hE2, 8'hE1, 8'hE0};
        bus3.m_ready_in  = 1'b1;
        push(0, 8'hAA, 1'b1);
        #1;
        chk("rst_mvalid", 32'(bus.m_valid_out), 0);
        chk("rst_sready", 32'(bus.s_ready_out), 0);
        chk("rst_mid",    32'(bus.m_id_out), 0);
        chk("rst_mdata",  32'(bus.m_data_out), 0);
        chk("rst_epoch",  32'(epoch), 0);

        // single stream: reload, then grant one cycle after the epoch pulse
        do_reset();
        bus.m_ready_in = 1'b1;
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
        @(negedge clk);
        chk("a_epoch",  32'(epoch), 1);
        chk("a_idle",   32'(bus.m_valid_out), 0);
        @(negedge clk);
        chk("a_id",     32'(bus.m_id_out), 1);
        chk("a_d0",     32'(bus.m_data_out), 8'h11);
        chk("a_sready", 32'(bus.s_ready_out), 4'b0010);
        chk("a_ep_lo",  32'(epoch), 0);
        @(negedge clk);
        chk("a_d1",     32'(bus.m_data_out), 8'h12);
        @(negedge clk);
        chk("a_d2",     32'(bus.m_data_out), 8'h13);
        chk("a_last",   32'(bus.m_last_out), 1);
        @(negedge clk);
        chk("a_bubble", 32'(bus.m_valid_out), 0);
        chk("a_bub_rdy", 32'(bus.s_ready_out), 0);
        push(1, 8'h14, 1'b1);
        @(negedge clk);
        chk("a_cred0_reload", 32'(epoch), 1);
        @(negedge clk);
        chk("a_d3",     32'(bus.m_data_out), 8'h14);
        chk("a_vld3",   32'(bus.m_valid_out), 1);

        // weighted share 3:1, weight-0 stream 2 never granted
        weight = {4'd0, 4'd0, 4'd1, 4'd3};
        do_reset();
        bus.m_ready_in = 1'b1;
        base = mon_n; eb = ep_n;
        for (int k = 0; k < 10; k++) begin
            push(0, 8'(k), 1'b1);
            push(1, 8'(8'h10 + k), 1'b1);
        end
        for (int k = 0; k < 5; k++) push(2, 8'(8'h20 + k), 1'b1);
        wait_mon(base + 8, "b_timeout");
        chk("b_epochs", 32'(ep_n - eb), 2);
        for (int k = 0; k < 8; k++) begin
            chk("b_id",   32'(mon_id[(base + k) % 64]), 32'(eid_b[k]));
            chk("b_data", 32'(mon_dat[(base + k) % 64]), 32'(edt_b[k]));
        end

        // packet atomicity with weight 1, credit saturates at 0
        weight = {4{4'd1}};
        do_reset();
        bus.m_ready_in = 1'b1;
        base = mon_n; eb = ep_n;
        for (int k = 0; k < 4; k++) push(0, 8'(8'hC0 + k), k == 3);
        push(1, 8'hD0, 1'b1);
        wait_mon(base + 5, "c_timeout");
        for (int k = 0; k < 4; k++) begin
            chk("c_id",   32'(mon_id[(base + k) % 64]), 0);
            chk("c_data", 32'(mon_dat[(base + k) % 64]), 32'(8'hC0 + k));
            chk("c_last", 32'(mon_last[(base + k) % 64]), 32'(k == 3));
        end
        chk("c_id4", 32'(mon_id[(base + 4) % 64]), 1);
        chk("c_ep1", 32'(ep_n - eb), 1);
        push(0, 8'hC4, 1'b1);
        wait_mon(base + 6, "c_timeout2");
        chk("c_id5", 32'(mon_id[(base + 5) % 64]), 0);
        chk("c_ep2", 32'(ep_n - eb), 2);

        // backpressure 1010 and a 2-cycle valid gap inside the packet
        weight = {4{4'd4}};
        do_reset();
        bus.m_ready_in = 1'b1;
        base = mon_n;
        for (int k = 0; k < 5; k++) push(2, 8'(8'h20 + k), k == 4);
        push(3, 8'h30, 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 6) begin
                chk("d_gap_vld", 32'(bus.m_valid_out), 0);
                chk("d_gap_id",  32'(bus.m_id_out), 2);
            end
            if (c == 7) chk("d_gap_rdy", 32'(bus.s_ready_out), 4'b0100);
            bus.m_ready_in = (c % 2 == 0);
            hold[2] = (c == 5 || c == 6);
        end
        chk("d_count", 32'(mon_n - base), 6);
        for (int k = 0; k < 5; k++) begin
            chk("d_id",   32'(mon_id[(base + k) % 64]), 2);
            chk("d_data", 32'(mon_dat[(base + k) % 64]), 32'(8'h20 + k));
        end
        chk("d_id5",   32'(mon_id[(base + 5) % 64]), 3);
        chk("d_data5", 32'(mon_dat[(base + 5) % 64]), 8'h30);

        // 3-stream wrap: 0,1,2, reload, 0,1
        do_reset();
        base = mon3_n; eb = ep3_n;
        bus3.s_valid_in = 3'b111;
        t = 0;
        while (mon3_n < base + 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("e_timeout", 32'(mon3_n >= base + 5), 1);
        chk("e_epochs", 32'(ep3_n - eb), 2);
        for (int k = 0; k < 5; k++) chk("e_id", 32'(mon3_id[(base + k) % 64]), 32'(eid_e[k]));
        bus3.s_valid_in = '0;

        // async reset during beat 2, then a fresh request must reload
        weight = {4{4'd2}};
        do_reset();
        bus.m_ready_in = 1'b1;
        push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
        t = 0;
        while (bus.m_data_out != 8'h52 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("f_beat2", 32'(bus.m_data_out), 8'h52);
        #2;
        rst_n = 1'b0;
        flush = 1'b1;
        #1;
        chk("f_rst_vld",  32'(bus.m_valid_out), 0);
        chk("f_rst_data", 32'(bus.m_data_out), 0);
        chk("f_rst_rdy",  32'(bus.s_ready_out), 0);
        chk("f_rst_last", 32'(bus.m_last_out), 0);
        chk("f_rst_id",   32'(bus.m_id_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b0;
        push(1, 8'h54, 1'b1);
        @(negedge clk);
        chk("f_reload", 32'(epoch), 1);
        chk("f_novld",  32'(bus.m_valid_out), 0);
        @(negedge clk);
        chk("f_data",   32'(bus.m_data_out), 8'h54);
        chk("f_id",     32'(bus.m_id_out), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
